// File: rtl/btn_pkg.sv
// btn_pkg
// Shared constants for the push-button conditioner.
//   CLK_HZ                  : system clock frequency the defaults assume (50 MHz)
//   DEBOUNCE_CYCLES_DEFAULT : 10 ms of stable input before a level is accepted
//   LONG_CYCLES_DEFAULT     : 1 s of continuous press before a long-press event
//   ms_to_cycles()          : converts milliseconds to clock cycles at CLK_HZ
// Long-press logic elsewhere is built only when BTN_LONG_PRESS_EN is defined.

package btn_pkg;

    localparam int CLK_HZ = 50000000;

    // Milliseconds to clock cycles at CLK_HZ.
    // The divide happens first so that ms * CLK_HZ cannot overflow 32 bits.
    function automatic int ms_to_cycles(input int ms);
        return ms * (CLK_HZ / 1000);
    endfunction

    localparam int DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(10);
    localparam int LONG_CYCLES_DEFAULT     = ms_to_cycles(1000);

endpackage

// File: rtl/btn_channel.sv
// btn_channel
// One button: 2-flop synchronizer, debounce counter, press/release pulses,
// toggle state and (when BTN_LONG_PRESS_EN is defined) a long-press pulse.
// Ports:
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   btn           : raw asynchronous button pin, 1 = pressed
//   level         : debounced level
//   press_pulse   : one-cycle pulse when level goes 0->1
//   release_pulse : one-cycle pulse when level goes 1->0
//   toggle        : inverts on every press
//   long_pulse    : one-cycle pulse after LONG_CYCLES-1 edges of accepted press
//                   (constant 0 without BTN_LONG_PRESS_EN)

module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle,
    output logic long_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer bringing the raw pin into the clock domain.
    // Both flops are reset so a button held through reset looks like a
    // fresh press once reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce: the synchronized value must differ from the accepted level
    // for DEBOUNCE_CYCLES consecutive edges before it is taken. Any return to
    // the accepted level restarts the count, so cnt never exceeds
    // DEBOUNCE_CYCLES-1. Event pulses and the toggle are registered on the
    // same edge that updates the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable        <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
                if (s2) begin
                    press_pulse <= 1'b1;
                    toggle      <= ~toggle;
                end else begin
                    release_pulse <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level = stable;

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    logic [HW-1:0] hcnt;

    // Hold counter: counts edges while the accepted level is high and
    // saturates at LONG_CYCLES-1. The pulse is raised only on the step into
    // saturation, so a long hold gives exactly one event and no repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt       <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (!stable) begin
                hcnt <= '0;
            end else if (hcnt != HW'(LONG_CYCLES - 1)) begin
                hcnt <= hcnt + HW'(1);
                if (hcnt == HW'(LONG_CYCLES - 2)) begin
                    long_pulse <= 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Conditions N_BTN raw push-button pins into clean levels and events.
// Each button is handled by an independent btn_channel.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   btn         : raw button pins, 1 = pressed
//   btn_level   : debounced levels
//   btn_press   : one-cycle press pulses
//   btn_release : one-cycle release pulses
//   btn_toggle  : per-button toggle state, flips on each press
//   btn_long    : one-cycle long-press pulses; constant 0 unless
//                 BTN_LONG_PRESS_EN is defined

module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_toggle,
    output logic [N_BTN-1:0] btn_long
);

    // One channel per button; channels share nothing but clock and reset.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn           (btn[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .toggle        (btn_toggle[i]),
            .long_pulse    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=8,
// LONG_CYCLES=32 and a 10 ns clock. Long-press expectations follow
// BTN_LONG_PRESS_EN in the same way as the design.

module tb_btn_conditioner;

    localparam int N = 3;
    localparam int D = 8;
    localparam int L = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_toggle;
    logic [N-1:0] btn_long;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    // Reference model stated in terms of observable rules: the synchronized
    // pin is the raw pin two edges late, a new level is accepted when the
    // last D synchronized samples all disagree with the current level, the
    // toggle is the parity of presses since reset, and a long press is due
    // exactly L-1 edges after a rising level that is still held.
    logic [N-1:0] mLevel, mPress, mRelease, mToggle, mLong;
    bit           modelValid = 1'b0;
    bit           prevRst = 1'b1;
    logic [N-1:0] prevRaw = '0;
    int           edgeNo = 0;
    int           pressCount [N];
    int           riseEdge [N];
    bit           win [N][$];

    always @(posedge clk) begin
        edgeNo++;
        if (rst) begin
            modelValid = 1'b1;
            mLevel = '0;
            mPress = '0;
            mRelease = '0;
            mToggle = '0;
            mLong = '0;
            for (int b = 0; b < N; b++) begin
                win[b].delete();
                pressCount[b] = 0;
                riseEdge[b] = -1;
            end
        end else begin
            for (int b = 0; b < N; b++) begin
                bit accept;
                bit synced;
                mPress[b] = 1'b0;
                mRelease[b] = 1'b0;
                mLong[b] = LONG_EN && mLevel[b] && (riseEdge[b] >= 0)
                           && (edgeNo == riseEdge[b] + L - 1);
                accept = (win[b].size() == D);
                foreach (win[b][k]) begin
                    if (win[b][k] == mLevel[b]) accept = 1'b0;
                end
                if (accept) begin
                    mLevel[b] = ~mLevel[b];
                    if (mLevel[b]) begin
                        mPress[b] = 1'b1;
                        pressCount[b]++;
                        riseEdge[b] = edgeNo;
                    end else begin
                        mRelease[b] = 1'b1;
                        riseEdge[b] = -1;
                    end
                end
                mToggle[b] = (pressCount[b] % 2) != 0;
                synced = prevRst ? 1'b0 : prevRaw[b];
                win[b].push_back(synced);
                if (win[b].size() > D) void'(win[b].pop_front());
            end
        end
        prevRst = rst;
        prevRaw = btn;
        #1;
        if (modelValid) begin
            compareField("level",   btn_level,   mLevel);
            compareField("press",   btn_press,   mPress);
            compareField("release", btn_release, mRelease);
            compareField("toggle",  btn_toggle,  mToggle);
            compareField("long",    btn_long,    mLong);
        end
    end

    task automatic compareField(input string name, input logic [N-1:0] act,
                                input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL model_%s edge %0d: got %b expected %b",
                     name, edgeNo, act, exp);
        end
    endtask

    // Literal checks with hand-computed expectations.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sticky observations over a stimulus phase.
    logic [N-1:0] accPress, accRelease;
    int           long2Pulses;

    task automatic clearAcc();
        accPress = '0;
        accRelease = '0;
        long2Pulses = 0;
    endtask

    // Inputs change only on falling edges, away from the sampling edge.
    task automatic applyStimulus(input logic r, input logic [N-1:0] b);
        rst = r;
        btn = b;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            accPress   = accPress | btn_press;
            accRelease = accRelease | btn_release;
            if (btn_long[2]) long2Pulses++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearAcc();
        // Buttons held through reset are reported as a fresh press.
        applyStimulus(1'b1, 3'b111);
        tick(3);
        checkOutput("reset_level",  btn_level,  3'b000);
        checkOutput("reset_press",  btn_press,  3'b000);
        checkOutput("reset_toggle", btn_toggle, 3'b000);
        applyStimulus(1'b0, 3'b111);
        tick(9);
        checkOutput("held_press_early", btn_press, 3'b000);
        checkOutput("held_level_early", btn_level, 3'b000);
        tick(1);
        checkOutput("held_press_edge10", btn_press,  3'b111);
        checkOutput("held_level_edge10", btn_level,  3'b111);
        checkOutput("held_toggle",       btn_toggle, 3'b111);
        tick(1);
        checkOutput("held_press_one_cycle", btn_press, 3'b000);

        // Reset clears toggle state too.
        applyStimulus(1'b1, 3'b000);
        tick(2);
        checkOutput("rst_clears_toggle", btn_toggle, 3'b000);
        checkOutput("rst_clears_level",  btn_level,  3'b000);
        applyStimulus(1'b0, 3'b000);
        tick(12);

        // Single button press then release.
        applyStimulus(1'b0, 3'b001);
        tick(10);
        checkOutput("b0_press",  btn_press,  3'b001);
        checkOutput("b0_level",  btn_level,  3'b001);
        checkOutput("b0_toggle", btn_toggle, 3'b001);
        tick(1);
        checkOutput("b0_press_one_cycle", btn_press, 3'b000);
        tick(3);
        applyStimulus(1'b0, 3'b000);
        tick(10);
        checkOutput("b0_release", btn_release, 3'b001);
        checkOutput("b0_level_low", btn_level, 3'b000);
        tick(1);
        checkOutput("b0_release_one_cycle", btn_release, 3'b000);

        // Bounce on btn[1] never lasts long enough to be accepted.
        clearAcc();
        applyStimulus(1'b0, 3'b010); tick(3);
        applyStimulus(1'b0, 3'b000); tick(1);
        applyStimulus(1'b0, 3'b010); tick(3);
        applyStimulus(1'b0, 3'b000); tick(16);
        checkOutput("bounce_no_press", accPress, 3'b000);
        checkOutput("bounce_level",    btn_level, 3'b000);

        // Two buttons in one cycle; second press on btn[0] toggles it back.
        clearAcc();
        applyStimulus(1'b0, 3'b101);
        tick(10);
        checkOutput("dual_press",  btn_press,  3'b101);
        checkOutput("dual_toggle", btn_toggle, 3'b100);
        tick(30);
        checkOutput("long_not_yet", btn_long, 3'b000);
        tick(1);
        checkOutput("long_edge31", btn_long, LONG_EN ? 3'b101 : 3'b000);
        tick(1);
        checkOutput("long_one_cycle", btn_long, 3'b000);
        tick(20);
        checkOutput("long_count", long2Pulses, LONG_EN ? 1 : 0);
        applyStimulus(1'b0, 3'b000);
        tick(10);
        checkOutput("dual_release", btn_release, 3'b101);
        tick(2);

        // Release before the long-press threshold.
        clearAcc();
        applyStimulus(1'b0, 3'b100);
        tick(20);
        applyStimulus(1'b0, 3'b000);
        tick(12);
        checkOutput("short_hold_no_long", long2Pulses, 0);
        checkOutput("short_hold_press",   accPress,   3'b100);
        checkOutput("short_hold_release", accRelease, 3'b100);

        // Reset in the middle of a debounce emits nothing.
        clearAcc();
        applyStimulus(1'b0, 3'b010);
        tick(5);
        applyStimulus(1'b1, 3'b010);
        tick(2);
        applyStimulus(1'b0, 3'b000);
        tick(15);
        checkOutput("mid_rst_no_press", accPress,   3'b000);
        checkOutput("mid_rst_level",    btn_level,  3'b000);
        checkOutput("mid_rst_toggle",   btn_toggle, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
